// File: rtl/code_encoder.sv
// SET_CODE frame serializer: header byte then a 32-bit code LSB byte first, over a valid/ready byte link.
// Optional inter-byte spacing is built when CODE_ENCODER_GAP_EN is defined.
module code_encoder #(
    parameter logic [7:0]  CMD_SET_CODE = 8'd1,
    parameter int unsigned GAP_CYCLES   = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iCode,
    input  logic        iCode_Valid,
    output logic        oCode_Ready,
    output logic [7:0]  oData,
    output logic        oData_Valid,
    input  logic        iData_Ready,
    output logic        oBusy,
    output logic        oDone
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

`ifdef CODE_ENCODER_GAP_EN
    localparam bit GAP_BUILT = 1'b1;
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    logic [7:0] gap_cnt_reg;
`else
    localparam bit GAP_BUILT = 1'b0;
`endif
    localparam bit GAP_ACTIVE = GAP_BUILT && (GAP_CYCLES != 0);

    state_t      state_reg;
    logic [31:0] code_reg;
    logic [2:0]  idx_reg;
    logic [7:0]  data_reg;
    logic        data_valid_reg;
    logic        code_ready_reg;
    logic        busy_reg;
    logic        done_reg;

    logic [7:0]  code_bytes [4];
    logic [2:0]  idx_next;
    logic [7:0]  byte_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign code_bytes[gi] = code_reg[8*gi +: 8];
        end
    endgenerate

    // The byte presented after a handshake is chosen from the held code by the incremented index.
    assign idx_next = idx_reg + 3'd1;

    always_comb begin
        byte_next = CMD_SET_CODE;
        case (idx_next)
            3'd1:    byte_next = code_bytes[0];
            3'd2:    byte_next = code_bytes[1];
            3'd3:    byte_next = code_bytes[2];
            3'd4:    byte_next = code_bytes[3];
            default: byte_next = CMD_SET_CODE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg      <= S_IDLE;
            code_reg       <= 32'd0;
            idx_reg        <= 3'd0;
            data_reg       <= 8'd0;
            data_valid_reg <= 1'b0;
            code_ready_reg <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
`ifdef CODE_ENCODER_GAP_EN
            gap_cnt_reg    <= 8'd0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (iCode_Valid && code_ready_reg) begin
                        code_reg       <= iCode;
                        idx_reg        <= 3'd0;
                        data_reg       <= CMD_SET_CODE;
                        data_valid_reg <= 1'b1;
                        code_ready_reg <= 1'b0;
                        busy_reg       <= 1'b1;
                        state_reg      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (data_valid_reg && iData_Ready) begin
                        if (idx_reg == 3'd4) begin
                            state_reg      <= S_DONE;
                            data_valid_reg <= 1'b0;
                            busy_reg       <= 1'b0;
                            done_reg       <= 1'b1;
                        end else begin
                            idx_reg  <= idx_next;
                            data_reg <= byte_next;
                            if (GAP_ACTIVE) begin
`ifdef CODE_ENCODER_GAP_EN
                                state_reg      <= S_GAP;
                                data_valid_reg <= 1'b0;
                                gap_cnt_reg    <= GAP_LOAD;
`endif
                            end
                        end
                    end
                end
`ifdef CODE_ENCODER_GAP_EN
                S_GAP: begin
                    if (gap_cnt_reg == 8'd0) begin
                        state_reg      <= S_SEND;
                        data_valid_reg <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 8'd1;
                    end
                end
`endif
                S_DONE: begin
                    state_reg      <= S_IDLE;
                    code_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg      <= S_IDLE;
                    data_valid_reg <= 1'b0;
                    code_ready_reg <= 1'b1;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign oCode_Ready = code_ready_reg;
    assign oData       = data_reg;
    assign oData_Valid = data_valid_reg;
    assign oBusy       = busy_reg;
    assign oDone       = done_reg;

endmodule

// File: tb/tb_code_encoder.sv
// Randomized self-checking bench for code_encoder: frames are checked against the expected byte list
// built from the code word, with backpressure, busy rejection, optional gaps and mid-frame reset.
module tb_code_encoder;

    localparam logic [7:0] CMD = 8'd1;
    localparam int GAP = 3;
`ifdef CODE_ENCODER_GAP_EN
    localparam int GAP_EFF = GAP;
`else
    localparam int GAP_EFF = 0;
`endif

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [31:0] iCode = 32'd0;
    logic        iCode_Valid = 1'b0;
    logic        oCode_Ready;
    logic [7:0]  oData;
    logic        oData_Valid;
    logic        iData_Ready = 1'b0;
    logic        oBusy;
    logic        oDone;

    int checks = 0;
    int errors = 0;

    always #5 iClk = ~iClk;

    code_encoder #(.CMD_SET_CODE(CMD), .GAP_CYCLES(GAP)) dut (
        .iClk(iClk), .iRst(iRst), .iCode(iCode), .iCode_Valid(iCode_Valid),
        .oCode_Ready(oCode_Ready), .oData(oData), .oData_Valid(oData_Valid),
        .iData_Ready(iData_Ready), .oBusy(oBusy), .oDone(oDone)
    );

    // mode 0: ready always high; 1: random ready; 2: 3-cycle stall at byte 2;
    // 3: ready high and 32'hCAFEF00D offered throughout the frame.
    task automatic send_frame(input logic [31:0] code, input int mode);
        logic [7:0] exp [5];
        logic [7:0] held;
        int k, lowrun, cyc, stall, got_lowrun;
        bit hv, hs;
        exp[0] = CMD;
        for (int b = 0; b < 4; b++) exp[b+1] = code[8*b +: 8];
        k = 0; lowrun = 0; cyc = 0; stall = 0; hv = 0; held = 8'd0;

        for (int t = 0; t < 100 && !oCode_Ready; t++) @(negedge iClk);
        checks++;
        if (oCode_Ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: oCode_Ready=%b required 1", oCode_Ready);
        end
        iCode = code;
        iCode_Valid = 1'b1;
        @(negedge iClk);
        iCode_Valid = (mode == 3);
        iCode = (mode == 3) ? 32'hCAFEF00D : $urandom;
        checks++;
        if (oData_Valid !== 1'b1 || oData !== CMD) begin
            errors++;
            $display("FAIL header_latency: valid=%b data=%h required 1/%h", oData_Valid, oData, CMD);
        end

        while (k < 5 && cyc < 300) begin
            checks++;
            if (oBusy !== 1'b1 || oCode_Ready !== 1'b0 || oDone !== 1'b0) begin
                errors++;
                $display("FAIL busy_flags: busy=%b ready=%b done=%b required 1/0/0", oBusy, oCode_Ready, oDone);
            end
            if (hv) begin
                checks++;
                if (oData_Valid !== 1'b1 || oData !== held) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b data=%h required 1/%h", oData_Valid, oData, held);
                end
            end
            if (oData_Valid) begin
                if (lowrun >= 0) begin
                    got_lowrun = lowrun;
                    checks++;
                    if (k > 0 && got_lowrun != GAP_EFF) begin
                        errors++;
                        $display("FAIL gap_len: byte %0d low cycles=%0d required %0d", k, got_lowrun, GAP_EFF);
                    end
                    lowrun = -1;
                end
                checks++;
                if (oData !== exp[k]) begin
                    errors++;
                    $display("FAIL byte%0d: data=%h required %h", k, oData, exp[k]);
                end
            end else if (lowrun >= 0) begin
                lowrun++;
            end
            case (mode)
                1: iData_Ready = $urandom_range(0, 1);
                2: iData_Ready = !(k == 2 && oData_Valid && stall < 3);
                default: iData_Ready = 1'b1;
            endcase
            if (mode == 2 && k == 2 && oData_Valid && !iData_Ready) stall++;
            hs = oData_Valid && iData_Ready;
            if (hs) begin
                k++;
                hv = 0;
                lowrun = 0;
            end else if (oData_Valid) begin
                hv = 1;
                held = oData;
            end
            @(negedge iClk);
            cyc++;
        end

        checks++;
        if (k != 5) begin
            errors++;
            $display("FAIL frame_timeout: bytes=%0d required 5", k);
        end
        if (mode == 0 && GAP_EFF == 0) begin
            checks++;
            if (cyc != 5) begin
                errors++;
                $display("FAIL stream_latency: cycles=%0d required 5", cyc);
            end
        end
        if (mode == 2) begin
            checks++;
            if (stall != 3) begin
                errors++;
                $display("FAIL stall_count: stall=%0d required 3", stall);
            end
        end
        checks++;
        if (oDone !== 1'b1 || oData_Valid !== 1'b0 || oCode_Ready !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle: done=%b valid=%b ready=%b busy=%b required 1/0/0/0",
                     oDone, oData_Valid, oCode_Ready, oBusy);
        end
        @(negedge iClk);
        checks++;
        if (oDone !== 1'b0 || oCode_Ready !== 1'b1 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL back_idle: done=%b ready=%b busy=%b required 0/1/0", oDone, oCode_Ready, oBusy);
        end
        $display("frame code=%h mode=%0d cycles=%0d", code, mode, cyc);
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        repeat (2) @(negedge iClk);
        checks++;
        if (oData !== 8'd0 || oData_Valid !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0 || oCode_Ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: data=%h valid=%b busy=%b done=%b ready=%b required 00/0/0/0/1",
                     oData, oData_Valid, oBusy, oDone, oCode_Ready);
        end
        iRst = 1'b0;
        @(negedge iClk);
        checks++;
        if (oCode_Ready !== 1'b1 || oData_Valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: ready=%b valid=%b required 1/0", oCode_Ready, oData_Valid);
        end
        $display("reset done");
    endtask

    task automatic test_basic();
        send_frame(32'hDEADBEEF, 0);
    endtask

    task automatic test_backpressure();
        send_frame(32'h12345678, 2);
    endtask

    task automatic test_busy_reject();
        send_frame(32'hA5A55A5A, 3);
        send_frame(32'hCAFEF00D, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) send_frame($urandom, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) send_frame($urandom, 0);
    endtask

    task automatic test_mid_reset();
        iData_Ready = 1'b1;
        iCode = 32'h89ABCDEF;
        iCode_Valid = 1'b1;
        @(negedge iClk);
        iCode_Valid = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (oData_Valid && oData == 8'hCD) break;
            @(negedge iClk);
        end
        checks++;
        if (oData_Valid !== 1'b1 || oData !== 8'hCD) begin
            errors++;
            $display("FAIL mid_reset_reach: valid=%b data=%h required 1/cd", oData_Valid, oData);
        end
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        checks++;
        if (oData_Valid !== 1'b0 || oDone !== 1'b0 || oCode_Ready !== 1'b1 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: valid=%b done=%b ready=%b busy=%b required 0/0/1/0",
                     oData_Valid, oDone, oCode_Ready, oBusy);
        end
        for (int t = 0; t < 6; t++) begin
            @(negedge iClk);
            checks++;
            if (oDone !== 1'b0 || oData_Valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet: done=%b valid=%b required 0/0", oDone, oData_Valid);
            end
        end
        $display("mid-frame reset done");
        send_frame(32'h00000001, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_reject();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
